// File: rtl/pipe_pkg.sv
// Shared state encodings and default widths for pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  localparam int unsigned DataWDef = 135;
  localparam int unsigned CtrlWDef = 1;
  localparam int unsigned CntWDef  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned W = CntWDef
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         INC,
  output logic [W-1:0] Q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (INC && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Q = cnt_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline stage register: two-entry skid buffer (SKID=1) or plain
// enable register (SKID=0), with flush and a saturating back-pressure counter.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned CTRL_W = CtrlWDef,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = CntWDef
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [CNT_W-1:0]  STALL_CNT
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid, in_ready_int, in_xfer, out_xfer;

  assign out_valid    = (state_q != StEmpty);
  assign in_ready_int = (SKID != 0) ? in_ready_q : (OUT_READY | ~out_valid);
  assign in_xfer      = IN_VALID & in_ready_int;
  assign out_xfer     = out_valid & OUT_READY;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (FLUSH) begin
      // Payload registers keep their value so OUT_DATA holds while empty.
      state_d = StEmpty;
    end else if (SKID != 0) begin
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            state_d     = StOne;
            main_data_d = IN_DATA;
            main_ctrl_d = IN_CTRL;
          end
        end
        StOne: begin
          if (in_xfer && out_xfer) begin
            main_data_d = IN_DATA;
            main_ctrl_d = IN_CTRL;
          end else if (in_xfer) begin
            state_d     = StTwo;
            skid_data_d = IN_DATA;
            skid_ctrl_d = IN_CTRL;
          end else if (out_xfer) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_xfer) begin
            state_d     = StOne;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end else begin
      if (in_xfer) begin
        state_d     = StOne;
        main_data_d = IN_DATA;
        main_ctrl_d = IN_CTRL;
      end else if (out_xfer) begin
        state_d = StEmpty;
      end
    end
    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Ready flop reloads to 1 during reset; gating by RESET gives 0 while held
  // and 1 in the very first cycle after release.
  assign IN_READY  = in_ready_int & ~RESET;
  assign OUT_VALID = out_valid;
  assign OUT_DATA  = main_data_q;
  assign OUT_CTRL  = out_valid ? main_ctrl_q : '0;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .RESET(RESET),
    .INC  (out_valid & ~OUT_READY),
    .Q    (STALL_CNT)
  );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboarded directed bench driving three configurations (skid, skid with
// 4-bit counter, plain register) from one shared stimulus stream.
module tb_pipe_stage_skid_reg;

  localparam int DW = 135;

  typedef struct packed {
    logic [0:0]    ctrl;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [0:0]    in_ctrl = '0;

  logic          ir [3];
  logic          ov [3];
  logic [DW-1:0] od [3];
  logic [0:0]    oc [3];
  logic [15:0]   a_cnt, n_cnt;
  logic [3:0]    s_cnt;

  int checks = 0;
  int failures = 0;
  ent_t sb [3][$];

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(1), .SKID(1), .CNT_W(16)) u_a (
    .CLK(clk), .RESET(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(ir[0]),
    .IN_DATA(in_data), .IN_CTRL(in_ctrl), .OUT_VALID(ov[0]), .OUT_READY(out_ready),
    .OUT_DATA(od[0]), .OUT_CTRL(oc[0]), .STALL_CNT(a_cnt));

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(1), .SKID(1), .CNT_W(4)) u_s (
    .CLK(clk), .RESET(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(ir[1]),
    .IN_DATA(in_data), .IN_CTRL(in_ctrl), .OUT_VALID(ov[1]), .OUT_READY(out_ready),
    .OUT_DATA(od[1]), .OUT_CTRL(oc[1]), .STALL_CNT(s_cnt));

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(1), .SKID(0), .CNT_W(16)) u_n (
    .CLK(clk), .RESET(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(ir[2]),
    .IN_DATA(in_data), .IN_CTRL(in_ctrl), .OUT_VALID(ov[2]), .OUT_READY(out_ready),
    .OUT_DATA(od[2]), .OUT_CTRL(oc[2]), .STALL_CNT(n_cnt));

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model sees pre-edge values: inputs only change on the falling edge.
  always @(posedge clk) begin
    ent_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        sb[i].delete();
      end else begin
        if (ov[i] === 1'b1 && out_ready) begin
          check($sformatf("dut%0d_out_has_entry", i), 160'(sb[i].size() != 0), 160'd1);
          if (sb[i].size() != 0) begin
            e = sb[i].pop_front();
            check($sformatf("dut%0d_out_data", i), 160'(od[i]), 160'(e.data));
            check($sformatf("dut%0d_out_ctrl", i), 160'(oc[i]), 160'(e.ctrl));
          end
        end
        if (flush) begin
          sb[i].delete();
        end else if (in_valid && ir[i] === 1'b1) begin
          e.ctrl = in_ctrl;
          e.data = in_data;
          sb[i].push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    // Reset held two cycles with an input offered.
    drive(135'h55, 1'b1);
    step();
    step();
    check("rst_out_valid", 160'(ov[0]), 160'd0);
    check("rst_out_ctrl", 160'(oc[0]), 160'd0);
    check("rst_out_data", 160'(od[0]), 160'd0);
    check("rst_stall_cnt", 160'(a_cnt), 160'd0);
    check("rst_sat_cnt", 160'(s_cnt), 160'd0);
    check("rst_in_ready", 160'(ir[0]), 160'd0);
    check("rst_in_ready_noskid", 160'(ir[2]), 160'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 160'(ir[0]), 160'd1);
    check("post_rst_in_ready_noskid", 160'(ir[2]), 160'd1);

    // Streaming at full rate.
    out_ready = 1'b1;
    drive(135'h1, 1'b1);
    step();
    check("stream_a_valid", 160'(ov[0]), 160'd1);
    check("stream_a_data", 160'(od[0]), 160'h1);
    check("stream_a_ready", 160'(ir[0]), 160'd1);
    drive(135'h2, 1'b0);
    step();
    check("stream_b_data", 160'(od[0]), 160'h2);
    check("stream_b_ready", 160'(ir[0]), 160'd1);
    drive(135'h3, 1'b1);
    step();
    check("stream_c_data", 160'(od[0]), 160'h3);
    check("stream_c_ctrl", 160'(oc[0]), 160'd1);
    check("stream_c_ready", 160'(ir[0]), 160'd1);
    in_valid = 1'b0;
    step();
    check("idle_valid", 160'(ov[0]), 160'd0);
    check("idle_ctrl_zero", 160'(oc[0]), 160'd0);
    check("idle_data_hold", 160'(od[0]), 160'h3);

    // Back-pressure fills main and skid, third entry waits upstream.
    drive(135'h11, 1'b1);
    step();
    out_ready = 1'b0;
    drive(135'h12, 1'b0);
    step();
    check("bp_ready_low", 160'(ir[0]), 160'd0);
    check("bp_head_data", 160'(od[0]), 160'h11);
    drive(135'h13, 1'b1);
    step();
    check("bp_ready_still_low", 160'(ir[0]), 160'd0);
    check("bp_stall_2", 160'(a_cnt), 160'd2);
    step();
    check("bp_stall_3", 160'(a_cnt), 160'd3);
    check("bp_head_held", 160'(od[0]), 160'h11);
    out_ready = 1'b1;
    step();
    check("bp_skid_to_main", 160'(od[0]), 160'h12);
    check("bp_ready_back", 160'(ir[0]), 160'd1);
    step();
    check("bp_third_data", 160'(od[0]), 160'h13);
    in_valid = 1'b0;
    step();
    check("bp_drained", 160'(ov[0]), 160'd0);
    check("bp_stall_final", 160'(a_cnt), 160'd3);
    check("bp_sat_cnt", 160'(s_cnt), 160'd3);

    // Flush from the two-entry state with an input offered.
    out_ready = 1'b0;
    drive(135'h21, 1'b0);
    step();
    drive(135'h22, 1'b1);
    step();
    check("fl_two_ready", 160'(ir[0]), 160'd0);
    drive(135'h2D, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", 160'(ov[0]), 160'd0);
    check("fl_ctrl", 160'(oc[0]), 160'd0);
    check("fl_ready", 160'(ir[0]), 160'd1);
    check("fl_stall_kept", 160'(a_cnt), 160'd5);
    out_ready = 1'b1;
    step();
    step();
    check("fl_nothing_emitted", 160'(ov[0]), 160'd0);

    // Flush coinciding with an output transfer and an input transfer.
    drive(135'h31, 1'b1);
    step();
    drive(135'h32, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flo_valid", 160'(ov[0]), 160'd0);
    check("flo_ready", 160'(ir[0]), 160'd1);
    step();
    check("flo_still_empty", 160'(ov[0]), 160'd0);

    // Stall counter saturation on the 4-bit instance.
    out_ready = 1'b0;
    drive(135'h41, 1'b1);
    step();
    in_valid = 1'b0;
    repeat (20) step();
    check("sat_at_max", 160'(s_cnt), 160'd15);
    check("wide_cnt_25", 160'(a_cnt), 160'd25);
    repeat (5) step();
    check("sat_stays_max", 160'(s_cnt), 160'd15);
    check("wide_cnt_30", 160'(a_cnt), 160'd30);
    check("sat_head_held", 160'(od[1]), 160'h41);
    out_ready = 1'b1;
    step();
    check("sat_drained", 160'(ov[1]), 160'd0);

    // Plain register: ready follows OUT_READY combinationally.
    out_ready = 1'b1;
    drive(135'h51, 1'b1);
    #1;
    check("ns_ready_empty", 160'(ir[2]), 160'd1);
    step();
    out_ready = 1'b0;
    drive(135'h52, 1'b0);
    #1;
    check("ns_ready_low", 160'(ir[2]), 160'd0);
    check("skid_ready_registered", 160'(ir[0]), 160'd1);
    step();
    check("ns_held", 160'(od[2]), 160'h51);
    out_ready = 1'b1;
    #1;
    check("ns_ready_high", 160'(ir[2]), 160'd1);
    step();
    check("ns_second", 160'(od[2]), 160'h52);
    drive(135'h53, 1'b1);
    step();
    check("ns_third", 160'(od[2]), 160'h53);
    in_valid = 1'b0;
    repeat (3) step();

    for (int i = 0; i < 3; i++) begin
      check($sformatf("dut%0d_sb_drained", i), 160'(sb[i].size()), 160'd0);
      check($sformatf("dut%0d_final_empty", i), 160'(ov[i]), 160'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
PIPE_STAGE_SKID_REG -- requirements
Module: pipe_stage_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 135, payload width (rd[4:0], wb_sel, pc+4, alu, imm, dmem).
REQ-002 SHALL have parameter CTRL_W, default 1, side-effect control bits (e.g. reg_write_en), gated by valid.
REQ-003 SHALL have parameter SKID, default 1; 1 = two-entry skid mode, 0 = single-register enable mode.
REQ-004 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-005 SHALL have port CLK  in  1  clock, all state updates on rising edge.
REQ-006 SHALL have port RESET  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port FLUSH  in  1  synchronous kill of all held entries.
REQ-008 SHALL have port IN_VALID  in  1  upstream entry present.
REQ-009 SHALL have port IN_READY  out  1  stage can accept.
REQ-010 SHALL have port IN_DATA  in  DATA_W  upstream payload.
REQ-011 SHALL have port IN_CTRL  in  CTRL_W  upstream control bits.
REQ-012 SHALL have port OUT_VALID  out  1  downstream entry present.
REQ-013 SHALL have port OUT_READY  in  1  downstream accepts (replaces BUSYWAIT as ~BUSYWAIT).
REQ-014 SHALL have port OUT_DATA  out  DATA_W  held payload.
REQ-015 SHALL have port OUT_CTRL  out  CTRL_W  held control, zero when OUT_VALID=0.
REQ-016 SHALL have port STALL_CNT  out  CNT_W  saturating count of back-pressured cycles.

Function
REQ-017 Input transfer SHALL occur on a rising edge with IN_VALID&IN_READY; output transfer with OUT_VALID&OUT_READY.
REQ-018 Latency SHALL be exactly 1 cycle from input transfer to OUT_VALID=1 when stage was empty.
REQ-019 Entries SHALL leave in acceptance order; none duplicated or dropped except by FLUSH/RESET.
REQ-020 SKID=1: state machine SHALL have states EMPTY, ONE (main reg), TWO (main+skid).
REQ-021 SKID=1: IN_READY SHALL be a registered output, 1 in EMPTY/ONE, 0 in TWO; no combinational path OUT_READY->IN_READY.
REQ-022 SKID=1 transitions: EMPTY->ONE on input; ONE->EMPTY on output w/o input; ONE->TWO on input w/o output; ONE stays on simultaneous in+out (main reloaded); TWO->ONE on output (skid moves to main).
REQ-023 SKID=0: IN_READY SHALL equal OUT_READY | ~OUT_VALID combinationally; single register, states EMPTY/ONE only.
REQ-024 OUT_DATA SHALL hold its last value when OUT_VALID=0 (never X); OUT_CTRL SHALL be forced to 0.
REQ-025 FLUSH SHALL empty the stage next cycle (OUT_VALID=0, state EMPTY, IN_READY=1), discarding any same-cycle input transfer.
REQ-026 FLUSH and OUT_READY simultaneously: current output transfer SHALL count as completed; nothing else emitted.
REQ-027 STALL_CNT SHALL increment each cycle with OUT_VALID=1 & OUT_READY=0, saturate at 2^CNT_W-1, unaffected by FLUSH.

Reset
REQ-028 RESET SHALL take priority over FLUSH and all transfers.
REQ-029 On RESET: state EMPTY, OUT_VALID=0, OUT_DATA=0, OUT_CTRL=0, STALL_CNT=0.
REQ-030 IN_READY SHALL be 0 while RESET is high and 1 in the first cycle after release.
REQ-031 RESET mid-operation SHALL discard both entries with no output transfer in the reset cycle.

Structure
REQ-032 State encodings (EMPTY=0, ONE=1, TWO=2) and default widths SHALL live in shared package pipe_pkg.
REQ-033 STALL_CNT SHALL be a sub-module sat_counter (parameter W; inputs CLK, RESET, INC; output Q).
REQ-034 mem_wb and other stage registers SHALL be instantiated from this block by width parameters only.

Verification
REQ-035 Reset: RESET high 2 cycles with IN_VALID=1 -> OUT_VALID=0, OUT_CTRL=0, STALL_CNT=0, IN_READY=0 then 1.
REQ-036 Stream: OUT_READY=1, inputs A=0x1, B=0x2, C=0x3 back-to-back -> outputs A,B,C on cycles 2,3,4, IN_READY stays 1.
REQ-037 Back-pressure SKID=1: OUT_READY=0 from cycle 2, inputs A,B,C -> A,B held, IN_READY=0 from cycle 3, C held upstream; release -> A,B,C in order, STALL_CNT counts stalled cycles.
REQ-038 Flush: state TWO, FLUSH=1 with IN_VALID=1 (D) -> next cycle OUT_VALID=0, OUT_CTRL=0, D never emitted, IN_READY=1.
REQ-039 Saturation: CNT_W=4, OUT_VALID=1, OUT_READY=0 for 20 cycles -> STALL_CNT=15, stays 15.
REQ-040 SKID=0: OUT_READY toggled 1,0,1 with continuous input -> IN_READY tracks OUT_READY same cycle, order preserved.
